pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 48 ++++
 rtl/pipe_perf.sv | 46 ++++
 rtl/pipe_ctrl.sv | 104 ++++++++++
 tb/tb_pipe_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types for the pipeline hazard/redirect controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int C_WORD_W = 64;

    typedef logic [C_WORD_W-1:0] word_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WAIT = 1'b1
    } pipe_ctrl_state_t;

    typedef struct packed {
        logic holdf;
        logic holdd;
        logic holde;
        logic holdm;
        logic bub_e;
        logic bub_m;
        logic bub_w;
    } pipe_hold_t;

    // A stage holds whenever any younger-facing stage downstream holds.
    function automatic pipe_hold_t calc_hold(
        input logic stallf_req,
        input logic bubbled,
        input logic busye,
        input logic stallm_req
    );
        pipe_hold_t h;
        h       = '0;
        h.holdm = stallm_req;
        h.holde = h.holdm | busye;
        h.holdd = h.holde | bubbled;
        h.holdf = h.holdd | stallf_req;
        h.bub_w = h.holdm;
        h.bub_m = h.holde & ~h.holdm;
        h.bub_e = h.holdd & ~h.holde;
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_perf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_perf
// Description : Free-running cycle, stall and redirect counters (wrap at 2^64).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_perf
    import pipe_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  holdd,
    input  logic  redirect_valid,
    output word_t perf_cycles,
    output word_t perf_stalls,
    output word_t perf_redirects
);

    word_t cycles_q, cycles_d;
    word_t stalls_q, stalls_d;
    word_t redirs_q, redirs_d;

    always_comb begin
        cycles_d = cycles_q + word_t'(1);
        stalls_d = stalls_q + word_t'(holdd);
        redirs_d = redirs_q + word_t'(redirect_valid);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles_q <= '0;
            stalls_q <= '0;
            redirs_q <= '0;
        end else begin
            cycles_q <= cycles_d;
            stalls_q <= stalls_d;
            redirs_q <= redirs_d;
        end
    end

    assign perf_cycles    = cycles_q;
    assign perf_stalls    = stalls_q;
    assign perf_redirects = redirs_q;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hold/bubble generation and branch redirect sequencing.
//               Define PIPE_PERF_CNT_EN to build the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  stallf_req,
    input  logic  bubbled,
    input  logic  busye,
    input  logic  stallm_req,
    input  logic  branch_valid,
    input  word_t branch_target,
    output logic  holdf,
    output logic  holdd,
    output logic  holde,
    output logic  holdm,
    output logic  flushd,
    output logic  bub_e,
    output logic  bub_m,
    output logic  bub_w,
    output logic  redirect_valid,
    output word_t redirect_pc,
    output word_t perf_cycles,
    output word_t perf_stalls,
    output word_t perf_redirects
);

    pipe_hold_t       w_hold;
    pipe_ctrl_state_t state_q, state_d;
    word_t            target_q, target_d;
    logic             w_accept;

    assign w_hold = calc_hold(stallf_req, bubbled, busye, stallm_req);

    assign holdf = w_hold.holdf;
    assign holdd = w_hold.holdd;
    assign holde = w_hold.holde;
    assign holdm = w_hold.holdm;
    assign bub_e = w_hold.bub_e;
    assign bub_m = w_hold.bub_m;
    assign bub_w = w_hold.bub_w;

    // WAIT leaves only on an idle fetch, so late execute/memory stalls
    // cannot cancel a redirect that is already pending.
    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        w_accept       = 1'b0;
        redirect_valid = 1'b0;
        case (state_q)
            RUN: begin
                if (branch_valid && !w_hold.holde) begin
                    w_accept = 1'b1;
                    target_d = branch_target;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (!stallf_req) begin
                    redirect_valid = 1'b1;
                    state_d        = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    assign flushd      = (w_accept | (state_q == WAIT) | bubbled) & ~w_hold.holde;
    assign redirect_pc = target_q;

`ifdef PIPE_PERF_CNT_EN
    pipe_perf u_perf (
        .clk            (clk),
        .reset          (reset),
        .holdd          (w_hold.holdd),
        .redirect_valid (redirect_valid),
        .perf_cycles    (perf_cycles),
        .perf_stalls    (perf_stalls),
        .perf_redirects (perf_redirects)
    );
`else
    assign perf_cycles    = '0;
    assign perf_stalls    = '0;
    assign perf_redirects = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed self-checking bench for pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic  clk;
    logic  reset;
    logic  stallf_req, bubbled, busye, stallm_req, branch_valid;
    word_t branch_target;
    logic  holdf, holdd, holde, holdm, flushd, bub_e, bub_m, bub_w;
    logic  redirect_valid;
    word_t redirect_pc, perf_cycles, perf_stalls, perf_redirects;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef PIPE_PERF_CNT_EN
    localparam bit C_PERF = 1'b1;
`else
    localparam bit C_PERF = 1'b0;
`endif

    pipe_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .stallf_req     (stallf_req),
        .bubbled        (bubbled),
        .busye          (busye),
        .stallm_req     (stallm_req),
        .branch_valid   (branch_valid),
        .branch_target  (branch_target),
        .holdf          (holdf),
        .holdd          (holdd),
        .holde          (holde),
        .holdm          (holdm),
        .flushd         (flushd),
        .bub_e          (bub_e),
        .bub_m          (bub_m),
        .bub_w          (bub_w),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .perf_cycles    (perf_cycles),
        .perf_stalls    (perf_stalls),
        .perf_redirects (perf_redirects)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive inputs just after a rising edge, then let the logic settle.
    task automatic drive(input logic sf, input logic bd, input logic be, input logic sm,
                         input logic bv, input word_t bt);
        stallf_req    = sf;
        bubbled       = bd;
        busye         = be;
        stallm_req    = sm;
        branch_valid  = bv;
        branch_target = bt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_holds(input string tag, input logic [6:0] exp);
        check({tag, ".holds"}, {holdf, holdd, holde, holdm, bub_e, bub_m, bub_w}, 64'(exp));
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, '0);
        #1;
        check("rst.redirect_valid", redirect_valid, 0);
        check("rst.redirect_pc", redirect_pc, 0);
        check("rst.perf_cycles", perf_cycles, 0);
        check("rst.perf_stalls", perf_stalls, 0);
        check("rst.perf_redirects", perf_redirects, 0);
        check("rst.flushd", flushd, 0);
        // holds stay combinational under reset
        drive(0, 0, 0, 1, 0, '0);
        check_holds("rst.stallm", 7'b1111_001);
        drive(0, 0, 0, 0, 0, '0);
        check_holds("rst.idle", 7'b0000_000);
        tick();
        tick();
        reset = 1'b1;

        // ---- counter window: 10 cycles, 3 holdd cycles, 1 redirect ----
        drive(0, 1, 0, 0, 0, '0);                          // c1 load-use
        check_holds("loaduse", 7'b1100_100);
        check("loaduse.flushd", flushd, 1);
        tick();
        drive(0, 0, 0, 1, 0, '0);                          // c2 mem stall
        check_holds("cnt.mem1", 7'b1111_001);
        tick();
        drive(0, 0, 0, 1, 0, '0);                          // c3 mem stall
        tick();
        drive(0, 0, 0, 0, 1, 64'h0000_0000_8000_0040);     // c4 branch, fetch idle
        check("idle.accept_flushd", flushd, 1);
        check("idle.no_early_redirect", redirect_valid, 0);
        tick();
        drive(0, 0, 0, 0, 0, '0);                          // c5 redirect
        check("idle.redirect_valid", redirect_valid, 1);
        check("idle.redirect_pc", redirect_pc, 64'h0000_0000_8000_0040);
        check("idle.wait_flushd", flushd, 1);
        tick();
        check("idle.back_to_run", redirect_valid, 0);      // c6
        check("idle.run_flushd", flushd, 0);
        check("idle.pc_held", redirect_pc, 64'h0000_0000_8000_0040);
        for (int i = 0; i < 5; i++) tick();                // c6..c10
        check("cnt.cycles", perf_cycles, C_PERF ? 64'd10 : 64'd0);
        check("cnt.stalls", perf_stalls, C_PERF ? 64'd3 : 64'd0);
        check("cnt.redirects", perf_redirects, C_PERF ? 64'd1 : 64'd0);

        // ---- memory stall for 3 cycles, branch pulse ignored ----
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, (i == 1), 64'h1234);
            check_holds($sformatf("memstall%0d", i), 7'b1111_001);
            check($sformatf("memstall%0d.flushd", i), flushd, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, '0);
        check_holds("memstall.end", 7'b0000_000);
        check("memstall.branch_ignored", redirect_valid, 0);
        tick();
        check("memstall.branch_ignored2", redirect_valid, 0);
        check("memstall.pc_unchanged", redirect_pc, 64'h0000_0000_8000_0040);

        // ---- busy-fetch branch: 4 WAIT cycles, then one pulse ----
        drive(1, 0, 0, 0, 1, 64'hDEAD_BEEF_0000_0100);
        check("busy.accept_flushd", flushd, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, '0);
            check($sformatf("busy.wait%0d.rv", i), redirect_valid, 0);
            check($sformatf("busy.wait%0d.flushd", i), flushd, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, '0);
        check("busy.redirect_valid", redirect_valid, 1);
        check("busy.redirect_pc", redirect_pc, 64'hDEAD_BEEF_0000_0100);
        tick();
        check("busy.single_pulse", redirect_valid, 0);

        // ---- stalls arriving in WAIT do not cancel the redirect ----
        drive(1, 0, 0, 0, 1, 64'h0000_0000_0000_0A00);
        tick();
        drive(1, 0, 1, 1, 0, '0);
        check("keep.holde_flushd", flushd, 0);
        check("keep.rv_low", redirect_valid, 0);
        tick();
        drive(0, 0, 1, 0, 0, '0);
        check("keep.redirect_valid", redirect_valid, 1);
        check("keep.redirect_pc", redirect_pc, 64'h0000_0000_0000_0A00);
        tick();
        drive(0, 0, 0, 0, 0, '0);
        check("keep.single_pulse", redirect_valid, 0);

        // ---- reset while WAIT drops the redirect ----
        drive(1, 0, 0, 0, 1, 64'h55);
        tick();
        drive(1, 0, 0, 0, 0, '0);
        check("rstwait.pending", redirect_valid, 0);
        reset = 1'b0;
        #1;
        check("rstwait.pc", redirect_pc, 0);
        check("rstwait.cycles", perf_cycles, 0);
        check("rstwait.stalls", perf_stalls, 0);
        check("rstwait.redirects", perf_redirects, 0);
        drive(0, 0, 0, 0, 0, '0);
        check("rstwait.in_reset_rv", redirect_valid, 0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("rstwait.after%0d.rv", i), redirect_valid, 0);
            tick();
        end
        check("rstwait.cycles_after", perf_cycles, C_PERF ? 64'd3 : 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
